// File: rtl/uart_tx_frame_arbiter.sv
// Two-channel (waveform/status) framer sharing one UART byte transmitter.
// Optional trailing XOR checksum byte: define UART_ARB_CHECKSUM_EN.
module uart_tx_frame_arbiter #(
    parameter logic [9:0] MAX_LEN  = 10'd405,
    parameter logic [7:0] HDR_WAVE = 8'hA5,
    parameter logic [7:0] HDR_STAT = 8'h5A
) (
    input  logic       in_clk,
    input  logic       in_rst,
    input  logic       wave_req,
    input  logic [9:0] wave_len,
    input  logic [7:0] wave_data,
    output logic       wave_rd,
    output logic       wave_done,
    input  logic       stat_req,
    input  logic [7:0] stat_data,
    output logic       stat_ack,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_done,
    output logic [1:0] grant,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_LENH = 3'd2,
        S_LENL = 3'd3,
        S_PAY  = 3'd4,
        S_DONE = 3'd5
`ifdef UART_ARB_CHECKSUM_EN
        ,
        S_CSUM = 3'd6
`endif
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_start_q, tx_start_d;
    logic       wave_rd_q, wave_rd_d;
    logic       wave_done_q;
    logic       stat_ack_q;
    logic [1:0] grant_q;
    logic       busy_q;
    logic [9:0] len_q;
    logic [9:0] cnt_q;
    logic [7:0] stat_byte_q;
    logic       own_stat_q;
    logic       last_stat_q;
`ifdef UART_ARB_CHECKSUM_EN
    logic [7:0] csum_q;
`endif

    logic       pick_stat;
    logic       pick_wave;
    logic [9:0] wave_len_clamp;
    logic       byte_done;
    logic       pay_last;
    logic [7:0] pay_byte;
    logic       go_tail;
    logic       enter_hdr;
    logic       enter_done;

    // Ties go to the channel that was not served last.
    assign pick_stat      = stat_req & (~wave_req | ~last_stat_q);
    assign pick_wave      = wave_req & ~pick_stat;
    assign wave_len_clamp = (wave_len > MAX_LEN) ? MAX_LEN : wave_len;
    assign byte_done      = tx_done & ~tx_start_q;
    assign pay_last       = (cnt_q + 10'd1) == len_q;
    assign pay_byte       = own_stat_q ? stat_byte_q : wave_data;
    assign enter_hdr      = (state_q == S_IDLE) & (state_d == S_HDR);
    assign enter_done     = (state_q != S_DONE) & (state_d == S_DONE);

    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        wave_rd_d  = 1'b0;
        go_tail    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (pick_stat | pick_wave) begin
                    state_d    = S_HDR;
                    tx_start_d = 1'b1;
                    tx_data_d  = pick_stat ? HDR_STAT : HDR_WAVE;
                end
            end
            S_HDR: begin
                if (byte_done) begin
                    state_d    = S_LENH;
                    tx_start_d = 1'b1;
                    tx_data_d  = {6'b0, len_q[9:8]};
                end
            end
            S_LENH: begin
                if (byte_done) begin
                    state_d    = S_LENL;
                    tx_start_d = 1'b1;
                    tx_data_d  = len_q[7:0];
                end
            end
            S_LENL: begin
                if (byte_done) begin
                    if (len_q != 10'd0) begin
                        state_d    = S_PAY;
                        tx_start_d = 1'b1;
                        tx_data_d  = pay_byte;
                        wave_rd_d  = ~own_stat_q;
                    end else begin
                        go_tail = 1'b1;
                    end
                end
            end
            S_PAY: begin
                if (byte_done) begin
                    if (pay_last) begin
                        go_tail = 1'b1;
                    end else begin
                        tx_start_d = 1'b1;
                        tx_data_d  = pay_byte;
                        wave_rd_d  = ~own_stat_q;
                    end
                end
            end
`ifdef UART_ARB_CHECKSUM_EN
            S_CSUM: begin
                if (byte_done) begin
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (go_tail) begin
`ifdef UART_ARB_CHECKSUM_EN
            state_d    = S_CSUM;
            tx_start_d = 1'b1;
            tx_data_d  = csum_q;
`else
            state_d    = S_DONE;
`endif
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q     <= S_IDLE;
            tx_data_q   <= 8'h00;
            tx_start_q  <= 1'b0;
            wave_rd_q   <= 1'b0;
            wave_done_q <= 1'b0;
            stat_ack_q  <= 1'b0;
            grant_q     <= 2'b00;
            busy_q      <= 1'b0;
            len_q       <= 10'd0;
            cnt_q       <= 10'd0;
            stat_byte_q <= 8'h00;
            own_stat_q  <= 1'b0;
            last_stat_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            wave_rd_q   <= wave_rd_d;
            wave_done_q <= 1'b0;
            stat_ack_q  <= 1'b0;
            if (enter_hdr) begin
                own_stat_q  <= pick_stat;
                len_q       <= pick_stat ? 10'd1 : wave_len_clamp;
                stat_byte_q <= stat_data;
                grant_q     <= pick_stat ? 2'b10 : 2'b01;
                busy_q      <= 1'b1;
                cnt_q       <= 10'd0;
            end
            if ((state_q == S_PAY) && byte_done) begin
                cnt_q <= cnt_q + 10'd1;
            end
            if (enter_done) begin
                wave_done_q <= ~own_stat_q;
                stat_ack_q  <= own_stat_q;
                last_stat_q <= own_stat_q;
            end
            if (state_q == S_DONE) begin
                grant_q <= 2'b00;
                busy_q  <= 1'b0;
            end
        end
    end

`ifdef UART_ARB_CHECKSUM_EN
    // Covers both length bytes and the payload; the header is left out.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            csum_q <= 8'h00;
        end else if (enter_hdr) begin
            csum_q <= 8'h00;
        end else if (tx_start_d &&
                     (state_d inside {S_LENH, S_LENL, S_PAY})) begin
            csum_q <= csum_q ^ tx_data_d;
        end
    end
`endif

    assign tx_data   = tx_data_q;
    assign tx_start  = tx_start_q;
    assign wave_rd   = wave_rd_q;
    assign wave_done = wave_done_q;
    assign stat_ack  = stat_ack_q;
    assign grant     = grant_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_tx_frame_arbiter.sv
// Scoreboard bench for uart_tx_frame_arbiter: predicted frames vs. the
// observed tx byte stream, grants, pops and completion pulses.
`timescale 1ns/1ps
module tb_uart_tx_frame_arbiter;

    logic       in_clk = 1'b0;
    logic       in_rst = 1'b1;
    logic       wave_req = 1'b0;
    logic [9:0] wave_len = 10'd0;
    logic [7:0] wave_data = 8'h00;
    logic       wave_rd;
    logic       wave_done;
    logic       stat_req = 1'b0;
    logic [7:0] stat_data = 8'h00;
    logic       stat_ack;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_done = 1'b0;
    logic [1:0] grant;
    logic       busy;

    uart_tx_frame_arbiter dut (
        .in_clk    (in_clk),
        .in_rst    (in_rst),
        .wave_req  (wave_req),
        .wave_len  (wave_len),
        .wave_data (wave_data),
        .wave_rd   (wave_rd),
        .wave_done (wave_done),
        .stat_req  (stat_req),
        .stat_data (stat_data),
        .stat_ack  (stat_ack),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_done   (tx_done),
        .grant     (grant),
        .busy      (busy)
    );

    always #5 in_clk = ~in_clk;

    typedef struct {
        bit st;
        int nb;
        int nr;
    } fr_t;

    logic [7:0] exp_b_q[$];
    fr_t        fr_q[$];
    logic [7:0] fifo_q[$];

    int  checks = 0;
    int  failures = 0;
    bit  last_stat = 1'b0;

    int  cyc = 0;
    int  done_cyc = 0;
    bit  mid = 1'b0;
    int  nb = 0;
    int  nr = 0;
    logic [1:0] prev_grant = 2'b00;
    fr_t fcur;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Expected frame from the framing rules: header, length, payload.
    task automatic predict(input bit ws, input int wl,
                           input logic [7:0] sd, input bit incr);
        int L;
        logic [9:0] l10;
        logic [7:0] b;
        fr_t f;
`ifdef UART_ARB_CHECKSUM_EN
        logic [7:0] cs;
`endif
        L = ws ? 1 : ((wl > 405) ? 405 : wl);
        l10 = L[9:0];
        exp_b_q.push_back(ws ? 8'h5A : 8'hA5);
        exp_b_q.push_back({6'b0, l10[9:8]});
        exp_b_q.push_back(l10[7:0]);
`ifdef UART_ARB_CHECKSUM_EN
        cs = {6'b0, l10[9:8]} ^ l10[7:0];
`endif
        for (int i = 0; i < L; i++) begin
            if (ws) b = sd;
            else if (incr) b = 8'(8'h11 * (i + 1));
            else b = 8'($urandom);
            if (!ws) fifo_q.push_back(b);
            exp_b_q.push_back(b);
`ifdef UART_ARB_CHECKSUM_EN
            cs = cs ^ b;
`endif
        end
`ifdef UART_ARB_CHECKSUM_EN
        exp_b_q.push_back(cs);
        f.nb = L + 4;
`else
        f.nb = L + 3;
`endif
        f.st = ws;
        f.nr = ws ? 0 : L;
        fr_q.push_back(f);
        last_stat = ws;
    endtask

    task automatic do_frame(input bit rs, input bit rw, input int wl,
                            input logic [7:0] sd, input bit incr);
        bit ws;
        int t;
        int lim;
        ws = (rs && rw) ? !last_stat : rs;
        predict(ws, wl, sd, incr);
        lim = 8 * (((wl > 405) ? 405 : wl) + 8) + 50;
        wave_len = wl[9:0];
        stat_data = sd;
        wave_req = rw;
        stat_req = rs;
        t = 0;
        do begin
            @(posedge in_clk); #1; t++;
        end while (grant == 2'b00 && t < 100);
        chk("grant_wait", {31'd0, grant != 2'b00}, 1);
        wave_req = 1'b0;
        stat_req = 1'b0;
        t = 0;
        do begin
            @(posedge in_clk); #1; t++;
        end while (!(wave_done | stat_ack) && t < lim);
        chk("done_wait", {31'd0, wave_done | stat_ack}, 1);
        repeat ($urandom_range(0, 3)) @(posedge in_clk);
        #1;
    endtask

    // Byte transmitter model: tx_done 1..4 cycles after each start.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge in_clk); #1;
            tx_done = 1'b0;
            if (in_rst) begin
                cnt = 0;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) tx_done = 1'b1;
            end else if (tx_start) begin
                cnt = $urandom_range(1, 4);
            end else if (!busy && $urandom_range(0, 7) == 0) begin
                tx_done = 1'b1;
            end
        end
    end

    // Show-ahead FIFO: head leaves at the edge closing the pop cycle.
    initial begin
        bit rd_pend;
        rd_pend = 1'b0;
        forever begin
            @(posedge in_clk); #1;
            if (rd_pend && fifo_q.size() > 0) void'(fifo_q.pop_front());
            rd_pend = wave_rd && !in_rst;
            wave_data = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
        end
    end

    always @(negedge in_clk) begin
        if (in_rst) begin
            mid = 1'b0;
            nb = 0;
            nr = 0;
            prev_grant = 2'b00;
        end else begin
            if (tx_done) done_cyc = cyc;
            if (grant != 2'b00 && prev_grant == 2'b00) begin
                if (fr_q.size() == 0) chk("grant_unexp", {30'd0, grant}, 0);
                else chk("grant", {30'd0, grant}, fr_q[0].st ? 2 : 1);
            end
            if (tx_start) begin
                if (exp_b_q.size() == 0) begin
                    chk("start_unexp", {31'd0, tx_start}, 0);
                end else begin
                    chk("tx_byte", {24'd0, tx_data}, {24'd0, exp_b_q.pop_front()});
                end
                chk("busy_on_start", {31'd0, busy}, 1);
                if (mid) chk("start_gap", cyc - done_cyc, 1);
                mid = 1'b1;
                nb++;
            end
            if (wave_rd) begin
                chk("rd_with_start", {31'd0, tx_start}, 1);
                chk("fifo_nonempty", {31'd0, fifo_q.size() > 0}, 1);
                nr++;
            end
            if (wave_done | stat_ack) begin
                if (fr_q.size() == 0) begin
                    chk("done_unexp", {30'd0, stat_ack, wave_done}, 0);
                end else begin
                    fcur = fr_q.pop_front();
                    chk("done_owner", {30'd0, stat_ack, wave_done},
                        fcur.st ? 2 : 1);
                    chk("frame_bytes", nb, fcur.nb);
                    chk("frame_pops", nr, fcur.nr);
                end
                mid = 1'b0;
                nb = 0;
                nr = 0;
            end
            prev_grant = grant;
        end
        cyc++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int m;
        int wl;
        // Reset with both requests pending; status must win the first tie.
        in_rst = 1'b1;
        wave_req = 1'b1;
        stat_req = 1'b1;
        repeat (3) begin
            @(posedge in_clk); #1;
            chk("reset_outs",
                {18'd0, tx_start, tx_data, wave_rd, wave_done, stat_ack,
                 grant, busy}, 0);
        end
        in_rst = 1'b0;
        last_stat = 1'b0;
        do_frame(1, 1, 3, 8'h77, 0);

        do_frame(1, 0, 0, 8'h3C, 0);
        do_frame(0, 1, 4, 8'h00, 1);
        do_frame(0, 1, 600, 8'h00, 0);
        do_frame(0, 1, 0, 8'h00, 0);
        do_frame(0, 1, 405, 8'h00, 0);

        // Three back-to-back frames with both requests held.
        for (int k = 0; k < 3; k++) predict(!last_stat, 5, 8'hC3, 0);
        wave_len = 10'd5;
        stat_data = 8'hC3;
        wave_req = 1'b1;
        stat_req = 1'b1;
        m = 0;
        t = 0;
        while (m < 3 && t < 1000) begin
            @(posedge in_clk); #1; t++;
            if (wave_done | stat_ack) m++;
        end
        wave_req = 1'b0;
        stat_req = 1'b0;
        chk("contention_frames", m, 3);
        repeat (3) @(posedge in_clk);
        #1;

        // Reset during the second payload byte of a waveform frame.
        predict(0, 10, 8'h00, 0);
        wave_len = 10'd10;
        wave_req = 1'b1;
        t = 0;
        do begin
            @(posedge in_clk); #1; t++;
        end while (grant == 2'b00 && t < 100);
        wave_req = 1'b0;
        t = 0;
        while (!(wave_rd && nr == 1) && t < 200) begin
            @(posedge in_clk); #1; t++;
        end
        chk("abort_point", {31'd0, wave_rd}, 1);
        in_rst = 1'b1;
        exp_b_q.delete();
        fr_q.delete();
        fifo_q.delete();
        last_stat = 1'b0;
        repeat (2) begin
            @(posedge in_clk); #1;
            chk("abort_reset_outs", {29'd0, tx_start, busy, wave_rd}, 0);
        end
        in_rst = 1'b0;
        repeat (10) begin
            @(posedge in_clk); #1;
            chk("abort_quiet", {29'd0, tx_start, busy, wave_rd}, 0);
        end
        do_frame(0, 1, 5, 8'h00, 0);

        for (int i = 0; i < 30; i++) begin
            m = $urandom_range(0, 2);
            wl = ($urandom_range(0, 9) == 0) ? $urandom_range(400, 700)
                                             : $urandom_range(0, 16);
            do_frame(m != 1, m != 0, wl, 8'($urandom), 0);
        end

        repeat (5) @(posedge in_clk);
        #1;
        chk("exp_bytes_left", exp_b_q.size(), 0);
        chk("exp_frames_left", fr_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
